// File: rtl/leiwand_rv32_wb_ram_pkg.sv
// Shared definitions for the Wishbone word RAM: FSM states, access size codes
// and the helper that sizes the word index.
package leiwand_rv32_wb_ram_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [2:0] SIZE_B = 3'd1;
  localparam logic [2:0] SIZE_H = 3'd2;
  localparam logic [2:0] SIZE_W = 3'd4;

  // Index of the highest set bit of value (0 for value 0 or 1).
  function automatic int HIGH_BIT_TO_FIT(input int value);
    int hb;
    hb = 0;
    for (int i = 0; i < 31; i++) begin
      if (value[i]) hb = i;
    end
    return hb;
  endfunction

endpackage

// File: rtl/leiwand_rv32_ram_lane.sv
// Byte-lane steering for sub-word writes: replicates the right-aligned write
// data across the word and selects the bytes to update.
module leiwand_rv32_ram_lane
  import leiwand_rv32_wb_ram_pkg::*;
(
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_dat,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdat,
  output logic        o_misalign
);

  // Decode size and low address bits into byte enables and steered data.
  always_comb begin
    o_be       = 4'b0000;
    o_wdat     = 32'h0;
    o_misalign = 1'b0;
    case (i_size)
      SIZE_B: begin
        o_be   = 4'b0001 << i_addr_lo;
        o_wdat = {4{i_dat[7:0]}};
      end
      SIZE_H: begin
        o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdat     = {2{i_dat[15:0]}};
        o_misalign = i_addr_lo[0];
      end
      SIZE_W: begin
        o_be       = 4'b1111;
        o_wdat     = i_dat;
        o_misalign = |i_addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/leiwand_rv32_wb_ram.sv
// Single-port word RAM behind a pipelined Wishbone slave. One access every
// three cycles: accept, execute, respond. Optional zero-fill sweep after reset.
//
// state   | meaning
// INIT    | post-reset; optional zero sweep, stalled
// IDLE    | ready to accept a request
// BUSY    | latched request checked and executed
// RESP    | one-cycle ack/err pulse on the bus
module leiwand_rv32_wb_ram
  import leiwand_rv32_wb_ram_pkg::*;
#(
  parameter int MEM_WIDTH    = 32,
  parameter int MEM_SIZE     = 1024,
  parameter int INIT_ZERO    = 0,
  parameter int MEM_HIGH_BIT = HIGH_BIT_TO_FIT(MEM_SIZE - 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [MEM_WIDTH-1:0] i_addr,
  input  logic [MEM_WIDTH-1:0] i_dat,
  output logic [MEM_WIDTH-1:0] o_dat,
  input  logic                 i_we,
  input  logic [2:0]           i_dat_wr_size,
  input  logic                 i_cyc,
  input  logic                 i_stb,
  output logic                 o_stall,
  output logic                 o_ack,
  output logic                 o_err
);

  localparam int IDX_W = MEM_HIGH_BIT + 1;
  localparam int CNT_W = IDX_W + 1;

  state_e               state_q, state_d;
  logic [MEM_WIDTH-1:0] addr_q, addr_d, dat_q, dat_d, rdat_q, rdat_d;
  logic                 we_q, we_d, ack_q, ack_d, err_q, err_d;
  logic [2:0]           size_q, size_d;
  logic [CNT_W-1:0]     init_idx_q, init_idx_d;

  logic [MEM_WIDTH-1:0] mem_q [MEM_SIZE];

  logic [3:0]           lane_be;
  logic [31:0]          lane_wdat;
  logic                 lane_misalign;
  logic                 size_bad, range_bad, req_err;
  logic [IDX_W-1:0]     req_idx;

  logic                 mem_we;
  logic [3:0]           mem_be;
  logic [IDX_W-1:0]     mem_widx;
  logic [MEM_WIDTH-1:0] mem_wdat;

  leiwand_rv32_ram_lane u_lane (
    .i_size     (size_q),
    .i_addr_lo  (addr_q[1:0]),
    .i_dat      (dat_q),
    .o_be       (lane_be),
    .o_wdat     (lane_wdat),
    .o_misalign (lane_misalign)
  );

  // Request validation; the range check uses the full word address so that
  // addresses beyond the array never alias onto low words.
  always_comb begin
    size_bad  = (size_q != SIZE_B) && (size_q != SIZE_H) && (size_q != SIZE_W);
    range_bad = (addr_q >> 2) >= MEM_WIDTH'(MEM_SIZE);
    req_err   = size_bad || lane_misalign || range_bad;
    req_idx   = addr_q[MEM_HIGH_BIT+2:2];
  end

  // Next-state, request latch, response and memory write control.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    size_d     = size_q;
    init_idx_d = init_idx_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdat_d     = '0;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;
    mem_widx   = req_idx;
    mem_wdat   = lane_wdat;
    case (state_q)
      ST_INIT: begin
        if (INIT_ZERO != 0) begin
          if (init_idx_q == CNT_W'(MEM_SIZE)) begin
            state_d = ST_IDLE;
          end else begin
            mem_we     = 1'b1;
            mem_be     = 4'b1111;
            mem_widx   = init_idx_q[IDX_W-1:0];
            mem_wdat   = '0;
            init_idx_d = init_idx_q + 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (i_cyc && i_stb) begin
          addr_d  = i_addr;
          dat_d   = i_dat;
          we_d    = i_we;
          size_d  = i_dat_wr_size;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!i_cyc) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
          if (req_err) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            if (we_q) begin
              mem_we = 1'b1;
              mem_be = lane_be;
            end else begin
              rdat_d = mem_q[req_idx];
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset aborts any access and restarts the sweep.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_INIT;
      addr_q     <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      size_q     <= 3'd0;
      init_idx_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdat_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      size_q     <= size_d;
      init_idx_q <= init_idx_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdat_q     <= rdat_d;
    end
  end

  // Byte-masked memory write; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_q[mem_widx][8*b +: 8] <= mem_wdat[8*b +: 8];
      end
    end
  end

  assign o_dat   = rdat_q;
  assign o_ack   = ack_q;
  assign o_err   = err_q;
  assign o_stall = (state_q != ST_IDLE);

endmodule
